// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode set, opcode width and the in-flight tag record shared by the arbiter and its bench.
package alu_pkg;
  localparam int OP_W     = 4;
  localparam int TAG_ID_W = 8;
  typedef enum logic [OP_W-1:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_PASS
  } alu_op_e;
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } alu_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching upward from rr_ptr; the pointer moves past each served index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  input  logic [W-1:0] adv_idx,
  output logic [N-1:0] grant
);
  logic [W-1:0] ptr_q, ptr_d;
  logic [W:0]   sum;
  logic [W-1:0] idx;
  // Walk from the farthest candidate to the nearest so the nearest valid requester wins.
  always_comb begin
    grant = '0;
    sum   = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum   = {1'b0, ptr_q} + (W+1)'(k);
      idx   = W'(sum >= (W+1)'(N) ? sum - (W+1)'(N) : sum);
      grant = req[idx] ? N'(1) << idx : grant;
    end
  end
  assign ptr_d = !advance ? ptr_q : adv_idx == W'(N - 1) ? '0 : adv_idx + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one fixed-latency ALU, with a latency-matched tag pipeline for response IDs.
// Define ALU_ARB_LOCK_EN to let a requester keep the grant across consecutive ops via req_lock.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 2,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*OP_W-1:0]    req_op,
  input  logic [N_REQ*DATA_W-1:0]  req_a,
  input  logic [N_REQ*DATA_W-1:0]  req_b,
  input  logic [N_REQ-1:0]         req_lock,
  output logic                     alu_valid,
  output logic [OP_W-1:0]          alu_op,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  input  logic                     alu_res_valid,
  input  logic [DATA_W-1:0]        alu_res,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     err
);
  logic [N_REQ-1:0]  rr_grant, grant;
  logic [ID_W-1:0]   gidx, issue_id_q, issue_id_d;
  logic              hs, alu_valid_q, alu_valid_d, err_q, err_d, unused_bits;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  alu_tag_t          tag_q [ALU_LAT];
  alu_tag_t          tag_d [ALU_LAT];

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (hs),
    .adv_idx (gidx),
    .grant   (rr_grant)
  );

`ifdef ALU_ARB_LOCK_EN
  logic            lock_act_q, lock_act_d, lock_hold;
  logic [ID_W-1:0] lock_own_q, lock_own_d;
  assign lock_hold = lock_act_q & req_valid[lock_own_q] & req_lock[lock_own_q];
  assign grant     = lock_hold ? N_REQ'(1) << lock_own_q : rr_grant;
  always_comb begin
    lock_act_d = hs & req_lock[gidx];
    lock_own_d = hs ? gidx : lock_own_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_act_q <= 1'b0;
      lock_own_q <= '0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
    end
  end
`else
  assign grant = rr_grant;
`endif

  assign req_ready = grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++) gidx = grant[i] ? ID_W'(i) : gidx;
    hs          = |(req_valid & grant);
    alu_valid_d = hs;
    alu_op_d    = hs ? '0 : alu_op_q;
    alu_a_d     = hs ? '0 : alu_a_q;
    alu_b_d     = hs ? '0 : alu_b_q;
    for (int i = 0; i < N_REQ; i++) begin
      alu_op_d = alu_op_d | ({OP_W{hs & grant[i]}} & req_op[i*OP_W +: OP_W]);
      alu_a_d  = alu_a_d | ({DATA_W{hs & grant[i]}} & req_a[i*DATA_W +: DATA_W]);
      alu_b_d  = alu_b_d | ({DATA_W{hs & grant[i]}} & req_b[i*DATA_W +: DATA_W]);
    end
    issue_id_d     = hs ? gidx : issue_id_q;
    tag_d[0].valid = alu_valid_q;
    tag_d[0].id    = TAG_ID_W'(issue_id_q);
    for (int s = 1; s < ALU_LAT; s++) tag_d[s] = tag_q[s-1];
    err_d = err_q | (alu_res_valid != tag_q[ALU_LAT-1].valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      issue_id_q  <= '0;
      err_q       <= 1'b0;
      for (int s = 0; s < ALU_LAT; s++) tag_q[s] <= '0;
    end else begin
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      issue_id_q  <= issue_id_d;
      err_q       <= err_d;
      for (int s = 0; s < ALU_LAT; s++) tag_q[s] <= tag_d[s];
    end
  end

  // The tag stage lines up with the ALU output, so the result passes straight through.
  assign alu_valid   = alu_valid_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp_valid   = tag_q[ALU_LAT-1].valid;
  assign rsp_id      = tag_q[ALU_LAT-1].id[ID_W-1:0];
  assign rsp_data    = rsp_valid ? alu_res : '0;
  assign err         = err_q;
  assign unused_bits = ^{req_lock, tag_q[ALU_LAT-1].id};
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized bench with a behavioural ALU and a queue-based grant/response reference model.
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int N = 4, DW = 32, LAT = 2;

  logic clk = 1'b0, rst_n = 1'b0, kill = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      req_valid, req_ready, req_lock;
  logic [N*OP_W-1:0] req_op;
  logic [N*DW-1:0]   req_a, req_b;
  logic              alu_valid, alu_res_valid, rsp_valid, err;
  logic [OP_W-1:0]   alu_op;
  logic [DW-1:0]     alu_a, alu_b, alu_res, rsp_data;
  logic [1:0]        rsp_id;
  int checks = 0, errors = 0, cyc = 0;

  alu_arbiter #(.N_REQ(N), .DATA_W(DW), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_lock(req_lock),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res_valid(alu_res_valid), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .err(err)
  );

  function automatic logic [DW-1:0] calc(logic [OP_W-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  // Behavioural ALU with LAT pipeline stages; kill suppresses its valid strobe.
  logic [DW-1:0] res_p [LAT];
  logic          v_p   [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin v_p[i] <= 1'b0; res_p[i] <= '0; end
    end else begin
      v_p[0]   <= alu_valid;
      res_p[0] <= calc(alu_op, alu_a, alu_b);
      for (int i = 1; i < LAT; i++) begin v_p[i] <= v_p[i-1]; res_p[i] <= res_p[i-1]; end
    end
  end
  assign alu_res_valid = v_p[LAT-1] & ~kill;
  assign alu_res       = res_p[LAT-1];

  // Reference model: pointer, lock owner and queue of expected responses.
  typedef struct { int due; int id; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];
  int   m_ptr = 0, m_own = 0;
  bit   m_lock = 0;

  function automatic int model_grant();
`ifdef ALU_ARB_LOCK_EN
    if (m_lock && req_valid[m_own] && req_lock[m_own]) return m_own;
`endif
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = 0; m_lock = 0; m_own = 0;
    end else begin
      int g;
      g = model_grant();
      cyc++;
      if (g >= 0) begin
        exp_q.push_back('{cyc + LAT, g, calc(req_op[g*OP_W +: OP_W], req_a[g*DW +: DW], req_b[g*DW +: DW])});
        m_ptr = (g + 1) % N; m_lock = req_lock[g]; m_own = g;
      end else m_lock = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit e;
      e = exp_q.size() > 0 && exp_q[0].due == cyc;
      checks++;
      if (rsp_valid !== e) begin
        errors++;
        $display("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, e);
      end
      if (e) begin
        checks++;
        if (rsp_id !== 2'(exp_q[0].id) || rsp_data !== exp_q[0].data) begin
          errors++;
          $display("FAIL rsp_payload cyc=%0d: got id=%0d data=%h expected id=%0d data=%h",
                   cyc, rsp_id, rsp_data, exp_q[0].id, exp_q[0].data);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
    end
  end

  task automatic set_req(int i, logic [OP_W-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    req_op[i*OP_W +: OP_W] = op;
    req_a[i*DW +: DW]      = a;
    req_b[i*DW +: DW]      = b;
  endtask

  task automatic rand_reqs();
    for (int i = 0; i < N; i++) set_req(i, OP_W'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic test_reset();
    req_valid = '0; req_lock = '0; req_op = '0; req_a = '0; req_b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({alu_valid, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, err, req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_values: got alu_valid=%b op=%h a=%h b=%h rsp_valid=%b id=%0d data=%h err=%b ready=%b expected all zero",
               alu_valid, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, err, req_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(2, OP_ADD, 32'd5, 32'd7);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if ({alu_valid, alu_op, alu_a, alu_b} !== {1'b1, OP_ADD, 32'd5, 32'd7}) begin
      errors++;
      $display("FAIL single_issue: got valid=%b op=%h a=%0d b=%0d expected 1/ADD/5/7", alu_valid, alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (alu_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_gap: got alu_valid=%b rsp_valid=%b expected 0/0", alu_valid, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'd12) begin
      errors++; $display("FAIL single_rsp: got valid=%b id=%0d data=%0d expected 1/2/12", rsp_valid, rsp_id, rsp_data);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rand_reqs();
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_grant: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr: got %b expected 0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      rand_reqs();
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'(1 << ((3 + k) % 4))) begin
        errors++; $display("FAIL b2b_grant k=%0d: got %b expected index %0d", k, req_ready, (3 + k) % 4);
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int g;
      @(negedge clk);
      rand_reqs();
      req_valid = N'($urandom);
      req_lock  = N'($urandom);
      #1;
      g = model_grant();
      checks++;
      if (req_ready !== (g < 0 ? 4'b0 : 4'(1 << g))) begin
        errors++; $display("FAIL random_grant k=%0d: got %b expected index %0d", k, req_ready, g);
      end
    end
    @(negedge clk);
    req_valid = '0; req_lock = '0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_mismatch();
    @(negedge clk);
    set_req(0, OP_XOR, $urandom, $urandom);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    kill = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL mismatch_cycle: got rsp_valid=%b err=%b expected 1/0", rsp_valid, err);
    end
    @(negedge clk);
    kill = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_sticky k=%0d: got %b expected 1", k, err); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    set_req(0, OP_ADD, $urandom, $urandom);
    req_valid = 4'b0001;
    @(negedge clk);
    set_req(1, OP_SUB, $urandom, $urandom);
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_valid, rsp_valid, err} !== 3'b000) begin
      errors++; $display("FAIL reset_async: got alu_valid=%b rsp_valid=%b err=%b expected 000", alu_valid, rsp_valid, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || err !== 1'b0) begin
        errors++; $display("FAIL reset_drop k=%0d: got rsp_valid=%b err=%b expected 0/0", k, rsp_valid, err);
      end
    end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr: got %b expected 0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_lock();
`ifdef ALU_ARB_LOCK_EN
    int exp_seq[5] = '{0, 0, 0, 1, 1};
`else
    int exp_seq[5] = '{0, 1, 0, 1, 1};
`endif
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rand_reqs();
      req_valid = k < 4 ? 4'b0011 : 4'b0010;
      req_lock  = k < 3 ? 4'b0001 : 4'b0000;
      #1;
      checks++;
      if (req_ready !== 4'(1 << exp_seq[k])) begin
        errors++; $display("FAIL lock_grant k=%0d: got %b expected index %0d", k, req_ready, exp_seq[k]);
      end
    end
    @(negedge clk);
    req_valid = '0; req_lock = '0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    @(negedge clk);
    test_back_to_back();
    test_random();
    test_mismatch();
    test_reset_inflight();
    test_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares one fixed-latency `alu` instance between `N_REQ` requesters. It accepts operations over per-requester valid/ready handshakes and registers the winning operation onto the ALU issue port. It tracks each in-flight operation's requester ID in a latency-matched tag pipeline and returns results tagged with that ID. It sits between the core/DMA-side requesters and the shared `alu` datapath.

## Interface
- `N_REQ`, 4: number of requesters. Must be ≥ 2.
- `DATA_W`, 32: operand and result width.
- `OP_W`, 4: opcode width. Taken from `alu_pkg`.
- `ALU_LAT`, 2: cycles from `alu_valid` high to `alu_res` valid. Must be ≥ 1.
- `ID_W`: derived localparam, `$clog2(N_REQ)`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `req_valid` in N_REQ: per-requester operation valid.
- `req_ready` out N_REQ: per-requester accept.
- `req_op` in N_REQ*OP_W: packed opcodes.
- `req_a`, `req_b` in N_REQ*DATA_W: packed operands.
- `req_lock` in N_REQ: keep grant across consecutive ops. Only effective with the macro enabled.
- `alu_valid` out 1: issue strobe to the ALU.
- `alu_op` out OP_W: opcode to the ALU.
- `alu_a`, `alu_b` out DATA_W: operands to the ALU.
- `alu_res_valid` in 1: ALU result strobe.
- `alu_res` in DATA_W: ALU result.
- `rsp_valid` out 1: result valid. No backpressure.
- `rsp_id` out ID_W: requester index for the result.
- `rsp_data` out DATA_W: result data.
- `err` out 1: sticky latency-mismatch flag.

## Operation
- **Grant:** combinational one-hot `grant` over `req_valid`.
  - Search starts at `rr_ptr` and wraps upward.
  - `req_ready = grant`. At most one bit is high.
  - With no valid requests, `req_ready` is all zero.
- **Handshake:** occurs on requester i when `req_valid[i] & req_ready[i]`.
  - `req_*` are sampled and registered onto `alu_op/a/b` with `alu_valid=1`.
  - `rr_ptr` ← (i+1) mod N_REQ.
- **Idle:** with no handshake, `alu_valid`=0, `alu_op/a/b` hold, `rr_ptr` holds.
- **Tag pipeline:** `ALU_LAT` stages of {valid, id}. Stage 0 loads {`alu_valid`, id of the issued op}.
- **Response:** when the last tag stage is valid:
  - `rsp_valid`=1
  - `rsp_id` = tag id
  - `rsp_data` = `alu_res`
- **Mismatch:** if `alu_res_valid` ≠ last tag valid in any cycle, `err` sets and stays set until reset. The response still follows the tag pipeline.
- **Throughput:** one issue per cycle.
- **Reset:** asynchronous assertion clears `rr_ptr`, `alu_valid`, all tag valids, `rsp_valid` and `err`.
  - In-flight operations are dropped; no response is produced for them.
  - Requesters must re-issue.

## Timing
- **Reset values:**
  - `alu_valid`=0, `alu_op/a/b`=0
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0
  - `err`=0
  - `rr_ptr`=0
- `req_ready` is combinational from `req_valid` and `rr_ptr` (and the lock state when enabled). It is valid in the same cycle.
- Handshake in cycle T → `alu_valid` high in T+1 → `rsp_valid` in T+1+ALU_LAT. Total latency 1+ALU_LAT (3 at the default).
- Back-to-back handshakes in T and T+1 produce responses in consecutive cycles, in issue order.
- All outputs except `req_ready` are registered.

## Configuration
- Macro: `ALU_ARB_LOCK_EN`.
- **Defined:**
  - A handshake with `req_lock[i]=1` sets `lock_own`=i.
  - While `req_valid[i] & req_lock[i]` holds, the grant stays on i and `rr_ptr` is not advanced.
  - The lock releases on the first cycle where `req_valid[i]` or `req_lock[i]` is low. Round-robin resumes from i+1.
- **Undefined:** `req_lock` is ignored and pure round-robin applies. The port remains for a stable interface.

## Structure
- **`alu_pkg`:**
  - `alu_op_e` enum and `OP_W`
  - `alu_tag_t` struct {valid, id}
- **Sub-module `rr_arbiter`:**
  - Parameter: `N`.
  - Inputs: `req`, `advance`, `adv_idx`.
  - Output: one-hot `grant`.
  - Owns `rr_ptr`.
- `alu_arbiter` holds the issue register, the tag pipeline, the error logic and the lock logic.

## Test plan
- Reset, then requester 2 alone valid with op ADD, a=5, b=7 → `req_ready`=0b0100; `alu_valid` in the next cycle; `rsp_valid`, `rsp_id`=2, `rsp_data`=12 three cycles after the handshake.
- All four requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; eight consecutive responses with matching ids.
- Requester 1 valid from pointer 3 (`rr_ptr` wrap) → grant 1; `rr_ptr` becomes 2.
- Force `alu_res_valid`=0 when the tag valid is 1 → `err`=1 and it stays 1; `rsp_valid` is still 1 that cycle.
- Assert `rst_n` low with 2 ops in flight → `rsp_valid` stays 0 after release; `rr_ptr`=0; `err`=0.
- `ALU_ARB_LOCK_EN` defined; requester 0 holds valid+lock for 3 ops while requester 1 is valid → grants 0,0,0, then 1 after lock drops.
